// File: rtl/usbh_report_decoder_multi_pkg.sv
// Shared types and constants for the multi-pad HID report decoder.
// Report bit positions, NES button indices, axis state and helpers.
package usbh_report_pkg;

    localparam int RPT_X_LSB = 0;
    localparam int RPT_Y_LSB = 8;
    localparam int RPT_B     = 45;
    localparam int RPT_A     = 46;
    localparam int RPT_RB    = 49;
    localparam int RPT_LT    = 50;
    localparam int RPT_RT    = 51;
    localparam int RPT_SEL   = 52;
    localparam int RPT_START = 53;

    localparam int BTN_A     = 0;
    localparam int BTN_B     = 1;
    localparam int BTN_SEL   = 2;
    localparam int BTN_START = 3;
    localparam int BTN_U     = 4;
    localparam int BTN_D     = 5;
    localparam int BTN_L     = 6;
    localparam int BTN_R     = 7;

    typedef enum logic [1:0] {
        AXIS_MID = 2'd0,
        AXIS_NEG = 2'd1,
        AXIS_POS = 2'd2
    } axis_t;

    // Only the report fields a channel actually consumes.
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       start;
        logic       sel;
        logic       b;
        logic       a;
        logic       af_b;
        logic       af_a;
    } pad_t;

    // Counter width for a 0..n-1 prescaler.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic pad_t pad_decode(input logic [63:0] r);
        pad_t p;
        p.x     = r[RPT_X_LSB +: 8];
        p.y     = r[RPT_Y_LSB +: 8];
        p.start = r[RPT_START];
        p.sel   = r[RPT_SEL];
        p.b     = r[RPT_B];
        p.a     = r[RPT_A];
        p.af_b  = r[RPT_RT];
        p.af_a  = r[RPT_LT] | r[RPT_RB];
        return p;
    endfunction

    function automatic axis_t axis_next(input axis_t st, input logic [7:0] v,
                                        input logic [7:0] neg_set, input logic [7:0] neg_rel,
                                        input logic [7:0] pos_set, input logic [7:0] pos_rel);
        axis_t n;
        case (st)
            AXIS_NEG: n = (v > pos_set) ? AXIS_POS : (v >= neg_rel) ? AXIS_MID : AXIS_NEG;
            AXIS_POS: n = (v < neg_set) ? AXIS_NEG : (v <= pos_rel) ? AXIS_MID : AXIS_POS;
            default:  n = (v < neg_set) ? AXIS_NEG : (v > pos_set) ? AXIS_POS : AXIS_MID;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/usbh_report_decoder_multi_if.sv
// Report stream from the USB host core: one tagged report per valid strobe.
interface usbh_report_decoder_multi_if;
    logic [63:0] i_report;
    logic        i_report_valid;
    logic [1:0]  i_report_ch;

    modport master (output i_report, output i_report_valid, output i_report_ch);
    modport slave  (input  i_report, input  i_report_valid, input  i_report_ch);
endinterface

// File: rtl/usbh_report_decoder_multi_channel.sv
// One player: held buttons, X/Y hysteresis FSMs, latched autofire sources
// and the silence watchdog that clears everything when the pad goes quiet.
module usbh_report_channel
    import usbh_report_pkg::*;
#(
    parameter int C_AXIS_LO    = 64,
    parameter int C_AXIS_HI    = 192,
    parameter int C_HYST       = 16,
    parameter int C_TIMEOUT_MS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       accept,
    input  logic       tick,
    input  pad_t       pad,
    output logic [7:0] held,
    output logic [1:0] af_src,
    output logic       connected
);
    localparam int              WD_W     = cnt_w(C_TIMEOUT_MS + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(C_TIMEOUT_MS);
    localparam logic [7:0]      NEG_SET  = 8'(C_AXIS_LO);
    localparam logic [7:0]      NEG_REL  = 8'(C_AXIS_LO + C_HYST);
    localparam logic [7:0]      POS_SET  = 8'(C_AXIS_HI);
    localparam logic [7:0]      POS_REL  = 8'(C_AXIS_HI - C_HYST);

    axis_t           ax_x, ax_y, ax_x_nxt, ax_y_nxt;
    logic [3:0]      keys;
    logic [WD_W-1:0] wd;
    logic            expire;

    // A report on the same cycle as the final tick keeps the channel alive.
    assign expire = tick && !accept && (wd != WD_LIMIT) && (wd + WD_W'(1) == WD_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            ax_x <= AXIS_MID;
            ax_y <= AXIS_MID;
        end else begin
            ax_x <= ax_x_nxt;
            ax_y <= ax_y_nxt;
        end
    end

    always_comb begin
        ax_x_nxt = ax_x;
        ax_y_nxt = ax_y;
        if (accept) begin
            ax_x_nxt = axis_next(ax_x, pad.x, NEG_SET, NEG_REL, POS_SET, POS_REL);
            ax_y_nxt = axis_next(ax_y, pad.y, NEG_SET, NEG_REL, POS_SET, POS_REL);
        end else if (expire) begin
            ax_x_nxt = AXIS_MID;
            ax_y_nxt = AXIS_MID;
        end
    end

    always_comb begin
        held             = '0;
        held[BTN_A]      = keys[0];
        held[BTN_B]      = keys[1];
        held[BTN_SEL]    = keys[2];
        held[BTN_START]  = keys[3];
        held[BTN_U]      = (ax_y == AXIS_NEG);
        held[BTN_D]      = (ax_y == AXIS_POS);
        held[BTN_L]      = (ax_x == AXIS_NEG);
        held[BTN_R]      = (ax_x == AXIS_POS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            keys      <= '0;
            af_src    <= '0;
            wd        <= '0;
            connected <= 1'b0;
        end else if (accept) begin
            keys      <= {pad.start, pad.sel, pad.b, pad.a};
            af_src    <= {pad.af_b, pad.af_a};
            wd        <= '0;
            connected <= 1'b1;
        end else if (tick && wd != WD_LIMIT) begin
            wd <= wd + WD_W'(1);
            if (expire) begin
                keys      <= '0;
                af_src    <= '0;
                connected <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/usbh_report_decoder_multi.sv
// Multi-pad HID joystick report decoder producing NES button bytes,
// with shared autofire phase and millisecond tick for the channel watchdogs.
module usbh_report_decoder_multi
    import usbh_report_pkg::*;
#(
    parameter int C_PLAYERS     = 2,
    parameter int C_CLK_HZ      = 6000000,
    parameter int C_AUTOFIRE_HZ = 10,
    parameter int C_AXIS_LO     = 64,
    parameter int C_AXIS_HI     = 192,
    parameter int C_HYST        = 16,
    parameter int C_TIMEOUT_MS  = 250
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    usbh_report_decoder_multi_if.slave rpt,
    input  logic                       i_autofire_en,
    output logic [8*C_PLAYERS-1:0]     o_btn,
    output logic [C_PLAYERS-1:0]       o_connected
);
    localparam int MS_DIV = (C_CLK_HZ / 1000 > 0) ? C_CLK_HZ / 1000 : 1;
    localparam int AF_DIV = (C_CLK_HZ / (2 * C_AUTOFIRE_HZ) > 0) ? C_CLK_HZ / (2 * C_AUTOFIRE_HZ) : 1;
    localparam int MS_W   = cnt_w(MS_DIV);
    localparam int AF_W   = cnt_w(AF_DIV);
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_DIV - 1);
    localparam logic [AF_W-1:0] AF_LAST = AF_W'(AF_DIV - 1);

    logic [MS_W-1:0]              ms_cnt;
    logic [AF_W-1:0]              af_cnt;
    logic                         ms_tick, af_wrap, phase;
    logic [C_PLAYERS-1:0]         accept;
    logic [C_PLAYERS-1:0][7:0]    held, btn_q;
    logic [C_PLAYERS-1:0][1:0]    af_src;
    pad_t                         pad;
    logic                         unused_rpt;

    assign pad        = pad_decode(rpt.i_report);
    assign unused_rpt = ^{rpt.i_report[63:54], rpt.i_report[48:47], rpt.i_report[44:16]};
    assign ms_tick    = (ms_cnt == MS_LAST);
    assign af_wrap    = (af_cnt == AF_LAST);

    // Both prescalers free-run; autofire enable only gates the output terms.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ms_cnt <= '0;
            af_cnt <= '0;
            phase  <= 1'b0;
        end else begin
            ms_cnt <= ms_tick ? '0 : ms_cnt + MS_W'(1);
            af_cnt <= af_wrap ? '0 : af_cnt + AF_W'(1);
            if (af_wrap) phase <= ~phase;
        end
    end

    for (genvar p = 0; p < C_PLAYERS; p++) begin : g_ch
        // Tags at or above C_PLAYERS match no channel and are dropped.
        assign accept[p] = rpt.i_report_valid && (rpt.i_report_ch == 2'(p));

        usbh_report_channel #(
            .C_AXIS_LO    (C_AXIS_LO),
            .C_AXIS_HI    (C_AXIS_HI),
            .C_HYST       (C_HYST),
            .C_TIMEOUT_MS (C_TIMEOUT_MS)
        ) u_ch (
            .clk       (i_clk),
            .rst       (i_reset),
            .accept    (accept[p]),
            .tick      (ms_tick),
            .pad       (pad),
            .held      (held[p]),
            .af_src    (af_src[p]),
            .connected (o_connected[p])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            btn_q <= '0;
        end else begin
            for (int p = 0; p < C_PLAYERS; p++)
                btn_q[p] <= held[p] | {6'b0, af_src[p] & {2{phase & i_autofire_en}}};
        end
    end

    assign o_btn = btn_q;

endmodule

// File: tb/tb_usbh_report_decoder_multi.sv
// Directed bench for usbh_report_decoder_multi with a fast clock so the
// ms tick is 20 cycles and the autofire half-period is 10 cycles.
module tb_usbh_report_decoder_multi;
    localparam int TMO = 10;
    localparam int MSD = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] btn;
    logic [1:0]  conn;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          rel, e1, exp_t, drop, p0, p1, hi, guard;
    logic        prev, found;
    logic [7:0]  hx   [10];
    logic [7:0]  hexp [10];

    usbh_report_decoder_multi_if rif();

    usbh_report_decoder_multi #(
        .C_PLAYERS(2), .C_CLK_HZ(20000), .C_AUTOFIRE_HZ(1000),
        .C_AXIS_LO(64), .C_AXIS_HI(192), .C_HYST(16), .C_TIMEOUT_MS(TMO)
    ) dut (
        .i_clk(clk), .i_reset(rst), .rpt(rif), .i_autofire_en(en),
        .o_btn(btn), .o_connected(conn)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [7:0] x, input logic [7:0] y,
                                       input logic a, input logic b, input logic sel,
                                       input logic st, input logic rb, input logic lt,
                                       input logic rt);
        logic [63:0] r;
        r = '0;
        r[7:0] = x;  r[15:8] = y;
        r[46] = a;   r[45] = b;   r[52] = sel; r[53] = st;
        r[49] = rb;  r[50] = lt;  r[51] = rt;
        return r;
    endfunction

    // Drive one valid cycle; returns at the negedge after the accepting edge.
    task automatic send(input logic [1:0] ch, input logic [63:0] r);
        rif.i_report       = r;
        rif.i_report_ch    = ch;
        rif.i_report_valid = 1'b1;
        @(negedge clk);
        rif.i_report_valid = 1'b0;
    endtask

    // First ms-tick edge strictly after edge e; ticks land every MSD edges after reset release.
    function automatic int next_tick(input int e);
        return rel + MSD * ((e - rel) / MSD + 1);
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        hx   = '{8'h45, 8'h50, 8'hFF, 8'hB5, 8'hAF, 8'h40, 8'hC0, 8'hC1, 8'h3F, 8'h4F};
        hexp = '{8'h40, 8'h00, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h80, 8'h40, 8'h40};
        rst = 1'b1; en = 1'b0;
        rif.i_report = '0; rif.i_report_ch = '0; rif.i_report_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_btn", btn, 16'h0000);
        chk("rst_conn", conn, 2'b00);
        rst = 1'b0;
        rel = cyc;

        send(2'd0, mk(8'h00, 8'h80, 1, 0, 0, 0, 0, 0, 0));
        chk("first_conn", conn, 2'b01);
        chk("first_lat", btn[7:0], 8'h00);
        @(negedge clk);
        chk("first_p0", btn[7:0], 8'h41);
        chk("first_p1", btn[15:8], 8'h00);

        for (int i = 0; i < 10; i++) begin
            send(2'd0, mk(hx[i], 8'h80, 0, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
            chk($sformatf("hyst_x%0d", i), btn[7:0], hexp[i]);
        end
        send(2'd0, mk(8'h80, 8'h10, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("y_up", btn[7:0], 8'h10);
        send(2'd0, mk(8'h80, 8'hF0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("y_flip_down", btn[7:0], 8'h20);
        send(2'd0, mk(8'h80, 8'h80, 0, 1, 1, 1, 0, 0, 0));
        @(negedge clk);
        chk("keys_bss", btn[7:0], 8'h0E);

        en = 1'b1;
        send(2'd1, mk(8'h80, 8'h80, 0, 0, 0, 0, 0, 1, 0));
        @(negedge clk);
        prev = btn[8]; p0 = -1; p1 = -1;
        for (int k = 0; k < 80 && p1 < 0; k++) begin
            @(negedge clk);
            if (btn[8] && !prev) begin
                if (p0 < 0) p0 = k; else p1 = k;
            end
            prev = btn[8];
        end
        chk("af_period", 32'((p1 >= 0) && (p1 - p0 >= 19) && (p1 - p0 <= 21)), 32'd1);
        chk("af_hi_byte", btn[15:8], 8'h01);
        en = 1'b0;
        @(negedge clk);
        chk("af_disable", btn[8], 1'b0);
        hi = 0;
        repeat (30) begin
            @(negedge clk);
            if (btn[8]) hi++;
        end
        chk("af_off_window", hi, 0);

        send(2'd0, mk(8'h00, 8'h80, 1, 0, 0, 0, 0, 0, 0));
        e1 = cyc;
        exp_t = next_tick(e1) + MSD * (TMO - 1);
        drop = -1;
        for (int k = 0; k < 300 && drop < 0; k++) begin
            if (k % 40 == 0) begin
                rif.i_report = mk(8'h80, 8'h80, 0, 1, 0, 0, 0, 0, 0);
                rif.i_report_ch = 2'd1;
                rif.i_report_valid = 1'b1;
            end else begin
                rif.i_report_valid = 1'b0;
            end
            @(negedge clk);
            if (!conn[0]) drop = cyc;
        end
        rif.i_report_valid = 1'b0;
        chk("wd_drop_edge", drop, exp_t);
        chk("wd_btn_lag", btn[7:0], 8'h41);
        @(negedge clk);
        chk("wd_btn_clr", btn[7:0], 8'h00);
        chk("wd_ch1_conn", conn[1], 1'b1);
        chk("wd_ch1_btn", btn[15:8], 8'h02);

        send(2'd0, mk(8'h80, 8'h80, 0, 0, 0, 1, 0, 0, 0));
        e1 = cyc;
        exp_t = next_tick(e1) + MSD * (TMO - 1);
        guard = 0;
        while (cyc < exp_t - 1 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        chk("wd_pre_tick", conn[0], 1'b1);
        send(2'd0, mk(8'hFF, 8'h80, 1, 0, 0, 0, 0, 0, 0));
        chk("wd_race_conn", conn[0], 1'b1);
        @(negedge clk);
        chk("wd_race_btn", btn[7:0], 8'h81);

        send(2'd1, mk(8'h80, 8'h80, 0, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("ign_pre", btn, 16'h0281);
        send(2'd3, mk(8'h00, 8'h00, 1, 1, 1, 1, 1, 1, 1));
        send(2'd2, mk(8'h00, 8'h00, 1, 1, 1, 1, 1, 1, 1));
        @(negedge clk);
        @(negedge clk);
        chk("ign_btn", btn, 16'h0281);
        chk("ign_conn", conn, 2'b11);

        en = 1'b1;
        send(2'd1, mk(8'h80, 8'h80, 0, 0, 0, 0, 0, 0, 1));
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (btn[9]) found = 1'b1;
        end
        chk("afb_seen", found, 1'b1);
        chk("afb_byte", btn[15:8], 8'h02);

        rst = 1'b1;
        @(negedge clk);
        chk("midrst_btn", btn, 16'h0000);
        chk("midrst_conn", conn, 2'b00);
        rst = 1'b0;
        rel = cyc;
        send(2'd1, mk(8'h80, 8'h80, 0, 0, 0, 0, 0, 1, 0));
        @(negedge clk);
        chk("rst_phase_lo", btn[8], 1'b0);
        repeat (10) @(negedge clk);
        chk("rst_phase_hi", btn[8], 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/usbh_report_decoder_multi.md
Name: usbh_report_decoder_multi

Overview:
Parametrised successor to the single-pad darfon/dragonrise HID decoder. It converts USB joystick reports from up to C_PLAYERS pads, multiplexed by channel tag, into per-player NES 8-bit button bytes. New features over the single-pad decoder: 8-bit axis thresholds with hysteresis, a runtime autofire enable and a rate-accurate autofire phase. A per-player report watchdog clears stale buttons when a pad stops reporting. It sits between the USB host core (same clock domain) and the NES controller shift-register ports.

Parameters:
C_PLAYERS, 2, number of pads/channels, 1..4.
C_CLK_HZ, 6000000, i_clk frequency in Hz.
C_AUTOFIRE_HZ, 10, autofire press rate; phase toggles at 2*C_AUTOFIRE_HZ.
C_AXIS_LO, 64, axis byte below this asserts L or U.
C_AXIS_HI, 192, axis byte above this asserts R or D.
C_HYST, 16, hysteresis band in axis LSBs; require C_AXIS_LO+C_HYST < C_AXIS_HI-C_HYST.
C_TIMEOUT_MS, 250, silence on a channel for this long marks it disconnected, 1..1023.

Ports:
i_clk  in  1  USB core clock.
i_reset  in  1  synchronous, active-high reset.
i_report  in  64  HID report: [7:0] X, [15:8] Y, [45] B, [46] A, [49] rbumper, [50] ltrigger, [51] rtrigger, [52] BACK/select, [53] start.
i_report_valid  in  1  one-cycle strobe, report belongs to i_report_ch.
i_report_ch  in  2  player index of the current report.
i_autofire_en  in  1  level; 0 forces autofire terms to 0.
o_btn  out  8*C_PLAYERS  player p at [8p+7:8p], order {R,L,D,U,start,select,B,A}.
o_connected  out  C_PLAYERS  1 while the channel has reported within the timeout.

Behaviour:
- Reset value of all state is 0: o_btn, o_connected, held buttons, axis states, autofire phase and prescaler, ms prescaler, watchdogs.
- Report accepted when i_report_valid=1 and i_report_ch<C_PLAYERS. Other channel values are ignored and leave no state change.
- Axis hysteresis, per axis per player, with states NEG/MID/POS:
  - MID->NEG when v<C_AXIS_LO. NEG->MID when v>=C_AXIS_LO+C_HYST.
  - MID->POS when v>C_AXIS_HI. POS->MID when v<=C_AXIS_HI-C_HYST.
  - NEG<->POS directly when the opposite threshold is crossed.
  - Evaluated only on accepted reports. NEG drives L/U, POS drives R/D. L&R and U&D are never both set.
- Held byte updates on the accepted cycle from the report bits: A=[46], B=[45], select=[52], start=[53].
- Autofire: prescaler counts 0..C_CLK_HZ/(2*C_AUTOFIRE_HZ)-1; on wrap, phase toggles. The prescaler free-runs and is unaffected by i_autofire_en.
  - af_a = ([50]|[49]) latched & phase & i_autofire_en.
  - af_b = [51] latched & phase & i_autofire_en.
- Output: o_btn byte = held | {6'b0, af_b, af_a}.
  - Latency: valid at cycle n -> held updated at n+1 -> o_btn at n+2.
  - i_autofire_en change reaches o_btn in 1 cycle.
- Watchdog: a shared ms tick every C_CLK_HZ/1000 cycles. The per-channel counter:
  - clears and sets o_connected=1 on an accepted report;
  - otherwise increments on each tick, saturating;
  - on reaching C_TIMEOUT_MS, o_connected=0 and held byte, latched autofire sources and axis states clear to 0/MID. o_btn for that player reads 0 two cycles later.
- Simultaneous accepted report and timeout on the same channel: the report wins (stays connected, new values loaded).
- Reset asserted mid-operation: all outputs 0 on the next edge. Autofire phase restarts at 0.

Decomposition:
- Package usbh_report_pkg holds:
  - report bit-position constants;
  - NES button index constants (BTN_A=0 … BTN_R=7);
  - the axis-state typedef {MID, NEG, POS};
  - clog2-derived prescaler widths.
- Sub-module usbh_report_channel holds one player's held byte, the two axis FSMs, latched autofire sources and the watchdog. It is instantiated C_PLAYERS times.
- The top holds channel decode, the autofire and ms prescalers, and output assembly.

Test Plan:
- Reset, then ch0 report X=0x00, Y=0x80, [46]=1 -> o_btn[7:0]=0x41 (L+A) two cycles after valid; o_btn[15:8]=0x00; o_connected=01.
- ch0 X sequence 0x00, 0x45, 0x50 -> L held at 0x45 (inside band), released at 0x50. X=0xFF -> R; then 0xB5 -> R held; then 0xAF -> released.
- ch1 report [50]=1, i_autofire_en=1 -> bit8 toggles with period C_CLK_HZ/C_AUTOFIRE_HZ cycles (±1). Drop i_autofire_en -> bit8=0 next cycle.
- ch0 reports then silence for C_TIMEOUT_MS ms -> o_connected[0]=0 and o_btn[7:0]=0; ch1 unaffected. A report landing on the timeout tick -> stays connected.
- i_report_ch=3 with C_PLAYERS=2 -> no output change. Reset pulse while buttons are held -> all outputs 0 next cycle.
